// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the single-register I2C write initiator.
//   - i2c_state_e   : FSM state encoding (IDLE, START, BYTE, ACK, STOP, FIN)
//   - I2C_NUM_BYTES : bytes per write (device address + W, register, data)
//   - I2C_START_TICKS / I2C_STOP_TICKS : ticks spent in START / STOP
//   - P0..P3        : bit phase values within one SCL bit period
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BYTE  = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_FIN   = 3'd5
  } i2c_state_e;

  localparam int CLK_TICKS_PER_BIT = 4;
  localparam int I2C_NUM_BYTES     = 3;
  localparam int I2C_START_TICKS   = 2;
  localparam int I2C_STOP_TICKS    = 3;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  // Phase value of the final step of the START and STOP sequences.
  localparam logic [1:0] START_LAST = 2'(I2C_START_TICKS - 1);
  localparam logic [1:0] STOP_LAST  = 2'(I2C_STOP_TICKS - 1);

endpackage

// File: rtl/i2c_bit_phase.sv
// i2c_bit_phase: step counter for the I2C writer FSM.
//   A 2-bit phase counter advances on every TICK; each wrap of the phase
//   counter advances a 3-bit bit counter. A synchronous clear restarts both
//   at zero and takes priority over TICK.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   tick        : one-cycle step strobe
//   clr         : restart phase and bit counters at 0
//   phase       : current phase (P0..P3)
//   last_phase  : phase is the last phase of a bit period
//   last_bit    : bit counter is on bit 7 of a byte
module i2c_bit_phase
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       clr,
  output logic [1:0] phase,
  output logic       last_phase,
  output logic       last_bit
);

  logic [2:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= P0;
      bit_cnt <= 3'd0;
    end else if (clr) begin
      phase   <= P0;
      bit_cnt <= 3'd0;
    end else if (tick) begin
      phase <= phase + 2'd1;
      if (last_phase) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign last_phase = (phase == 2'(CLK_TICKS_PER_BIT - 1));
  assign last_bit   = (bit_cnt == 3'd7);

endmodule

// File: rtl/i2c_reg_writer.sv
// i2c_reg_writer: single-register I2C write initiator.
//   On an accepted START request it issues an I2C START condition, three
//   bytes ({DEV_ADDR,W}, REG_ADDR, DATA) each followed by an ACK bit, then a
//   STOP condition. Bit timing is paced by TICK (4 ticks per SCL period);
//   every FSM step consumes exactly one tick, except FIN which completes on
//   the next clock.
// Ports:
//   CLK, RST_n : system clock, asynchronous active-low reset
//   TICK       : one-cycle step strobe
//   START      : write request, sampled only while BUSY=0
//   DEV_ADDR   : 7-bit device address (latched on accept)
//   REG_ADDR   : register address (latched on accept)
//   DATA       : register data (latched on accept)
//   BUSY       : high from the cycle after accept until DONE
//   DONE       : one-cycle completion pulse
//   ACK_ERR    : a NACK was seen in the last transaction (valid with DONE)
//   SCL        : serial clock, push-pull, idle high
//   SDA_OE     : 1 pulls SDA low, 0 releases it
//   SDA_I      : sampled SDA line (assumed already synchronous to CLK)
//   STATE_DBG  : current FSM state, for observation only
// Handshake: a request is taken on any CLK edge where START=1 and BUSY=0;
//   inputs are captured on that edge and later changes are ignored until
//   the DONE pulse, in whose cycle a new request may already be taken.
// Build option: I2C_WRITER_ABORT_ON_NACK_EN -- when defined, a NACK ends the
//   transfer with STOP right after the offending ACK bit; when undefined all
//   three bytes are always sent and ACK_ERR accumulates.
module i2c_reg_writer
  import i2c_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       TICK,
  input  logic       START,
  input  logic [6:0] DEV_ADDR,
  input  logic [7:0] REG_ADDR,
  input  logic [7:0] DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ACK_ERR,
  output logic       SCL,
  output logic       SDA_OE,
  input  logic       SDA_I,
  output i2c_state_e STATE_DBG
);

`ifdef I2C_WRITER_ABORT_ON_NACK_EN
  localparam bit ABORT_ON_NACK = 1'b1;
`else
  localparam bit ABORT_ON_NACK = 1'b0;
`endif

  i2c_state_e state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d, next_idx;
  logic [7:0] sh_q, sh_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic [7:0] next_byte;
  logic       scl_d, sda_oe_d, busy_d, done_d, ack_err_d;

  logic [1:0] phase;
  logic       last_phase, last_bit;
  logic       phase_clr;

  // Counters restart whenever the FSM changes state, and are held at zero
  // while idle, so every state begins at phase P0 / bit 0.
  assign phase_clr = (state_d != state_q) || (state_q == ST_IDLE);

  i2c_bit_phase u_bit_phase (
    .clk        (CLK),
    .rst_n      (RST_n),
    .tick       (TICK),
    .clr        (phase_clr),
    .phase      (phase),
    .last_phase (last_phase),
    .last_bit   (last_bit)
  );

  // Byte 0 is loaded straight from the inputs on accept; later bytes come
  // from the latched copies.
  assign next_idx  = byte_idx_q + 2'd1;
  assign next_byte = (next_idx == 2'd1) ? reg_q : data_q;

  always_comb begin
    state_d    = state_q;
    scl_d      = SCL;
    sda_oe_d   = SDA_OE;
    busy_d     = BUSY;
    done_d     = 1'b0;
    ack_err_d  = ACK_ERR;
    byte_idx_d = byte_idx_q;
    sh_d       = sh_q;
    reg_d      = reg_q;
    data_d     = data_q;

    case (state_q)
      ST_IDLE: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        busy_d   = 1'b0;
        // Accept is edge-based, independent of TICK.
        if (START) begin
          reg_d      = REG_ADDR;
          data_d     = DATA;
          sh_d       = {DEV_ADDR, 1'b0};
          ack_err_d  = 1'b0;
          byte_idx_d = 2'd0;
          busy_d     = 1'b1;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (TICK) begin
          if (phase == START_LAST) begin
            scl_d   = 1'b0;
            state_d = ST_BYTE;
          end else begin
            // SDA falls while SCL is still high: the START condition.
            sda_oe_d = 1'b1;
          end
        end
      end

      ST_BYTE: begin
        if (TICK) begin
          case (phase)
            P0: begin
              scl_d    = 1'b0;
              sda_oe_d = ~sh_q[7];
            end
            P1:      scl_d = 1'b1;
            P2:      scl_d = 1'b1;
            default: begin
              scl_d = 1'b0;
              sh_d  = {sh_q[6:0], 1'b0};
              if (last_bit) begin
                state_d = ST_ACK;
              end
            end
          endcase
        end
      end

      ST_ACK: begin
        if (TICK) begin
          case (phase)
            P0: begin
              scl_d    = 1'b0;
              sda_oe_d = 1'b0;
            end
            P1: scl_d = 1'b1;
            P2: begin
              scl_d = 1'b1;
              if (SDA_I) begin
                ack_err_d = 1'b1;
              end
            end
            default: begin
              scl_d      = 1'b0;
              byte_idx_d = next_idx;
              // ACK_ERR already reflects this bit's NACK (sampled at P2).
              if ((ABORT_ON_NACK && ACK_ERR) ||
                  (next_idx >= 2'(I2C_NUM_BYTES))) begin
                state_d = ST_STOP;
              end else begin
                sh_d    = next_byte;
                state_d = ST_BYTE;
              end
            end
          endcase
        end
      end

      ST_STOP: begin
        if (TICK) begin
          if (phase == STOP_LAST) begin
            // SDA rises while SCL is high: the STOP condition.
            sda_oe_d = 1'b0;
            state_d  = ST_FIN;
          end else if (phase == P0) begin
            scl_d    = 1'b0;
            sda_oe_d = 1'b1;
          end else begin
            scl_d = 1'b1;
          end
        end
      end

      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      SCL        <= 1'b1;
      SDA_OE     <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ACK_ERR    <= 1'b0;
      byte_idx_q <= 2'd0;
      sh_q       <= 8'd0;
      reg_q      <= 8'd0;
      data_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      SCL        <= scl_d;
      SDA_OE     <= sda_oe_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
      ACK_ERR    <= ack_err_d;
      byte_idx_q <= byte_idx_d;
      sh_q       <= sh_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
    end
  end

  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// tb_i2c_reg_writer: self-checking bench for i2c_reg_writer.
//   Stimulus pushes the expected outcome of each accepted write into exp_q;
//   a monitor decodes the I2C bus (START/STOP conditions, bits on SCL rise),
//   counts ticks, models an ACKing/NACKing slave and, on each DONE, pops and
//   compares. Honours I2C_WRITER_ABORT_ON_NACK_EN the same way as the design.
module tb_i2c_reg_writer;
  import i2c_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       TICK = 1'b0;
  logic       START = 1'b0;
  logic [6:0] DEV_ADDR = '0;
  logic [7:0] REG_ADDR = '0;
  logic [7:0] DATA = '0;
  logic       BUSY, DONE, ACK_ERR, SCL, SDA_OE, SDA_I;
  i2c_state_e STATE_DBG;

  logic       slave_pull = 1'b0;
  logic [2:0] nack_mask = 3'b000;

  // Open-drain line: low if either master or slave pulls.
  assign SDA_I = ~SDA_OE & ~slave_pull;

  always #5 CLK = ~CLK;

  i2c_reg_writer dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .TICK      (TICK),
    .START     (START),
    .DEV_ADDR  (DEV_ADDR),
    .REG_ADDR  (REG_ADDR),
    .DATA      (DATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ACK_ERR   (ACK_ERR),
    .SCL       (SCL),
    .SDA_OE    (SDA_OE),
    .SDA_I     (SDA_I),
    .STATE_DBG (STATE_DBG)
  );

  // Tick strobe with random spacing of 2..4 cycles.
  initial begin
    int gap;
    gap = 2;
    forever begin
      @(posedge CLK);
      #1;
      if (gap == 0) begin
        TICK = 1'b1;
        gap  = $urandom_range(1, 3);
      end else begin
        TICK = 1'b0;
        gap--;
      end
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // {ack_err, nbytes[1:0], ticks[6:0], byte0, byte1, byte2}
  localparam int W = 34;
  logic [W-1:0] exp_q[$];

  // Reference model: what a write should look like on the bus.
  function automatic logic [W-1:0] model(input logic [6:0] d, input logic [7:0] r,
                                         input logic [7:0] v, input logic [2:0] m);
    int   nb;
    int   ticks;
    logic aerr;
    nb = 3;
`ifdef I2C_WRITER_ABORT_ON_NACK_EN
    for (int j = 2; j >= 0; j--) begin
      if (m[j]) nb = j + 1;
    end
`endif
    ticks = 2 + 36 * nb + 3;
    aerr  = 1'b0;
    for (int j = 0; j < nb; j++) aerr = aerr | m[j];
    return {aerr, 2'(nb), 7'(ticks), d, 1'b0, r, v};
  endfunction

  // ---------------- monitor + slave model ----------------
  int   cyc = 0, done_cnt = 0, accept_cnt = 0, tick_cnt = 0, last_tick_cyc = 0;
  int   start_cnt = 0, stop_cnt = 0, rise_cnt = 0;
  int   busy_low_len = 0, last_busy_low_len = 0;
  bit   in_txn = 1'b0, accept_pend = 1'b0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic bits[$];
  logic [W-1:0] mon_e;

  always @(negedge CLK) begin
    cyc++;
    if (!RST_n) begin
      in_txn      = 1'b0;
      accept_pend = 1'b0;
      slave_pull  = 1'b0;
      rise_cnt    = 0;
      bits.delete();
      busy_low_len = 0;
      prev_scl    = SCL;
      prev_sda    = ~SDA_OE;
    end else begin
      if (accept_pend) begin
        chk("busy_rise", BUSY, 1);
        accept_pend = 1'b0;
      end
      // bus decoding
      if (prev_scl && SCL && prev_sda && !SDA_I) start_cnt++;
      if (prev_scl && SCL && !prev_sda && SDA_I) stop_cnt++;
      if (!prev_scl && SCL) begin
        bits.push_back(SDA_I);
        rise_cnt++;
      end
      // slave: drive the 9th bit of each byte low unless told to NACK it
      if (prev_scl && !SCL) begin
        if ((rise_cnt % 9 == 8) && (rise_cnt / 9 < 3))
          slave_pull = ~nack_mask[rise_cnt / 9];
        else
          slave_pull = 1'b0;
      end
      prev_scl = SCL;
      prev_sda = ~SDA_OE & ~slave_pull;

      if (DONE) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          int nb;
          mon_e = exp_q.pop_front();
          nb = int'(mon_e[32:31]);
          chk("tick_count", tick_cnt, 32'(mon_e[30:24]));
          chk("done_after_last_tick", cyc - last_tick_cyc, 2);
          chk("ack_err", ACK_ERR, 32'(mon_e[33]));
          chk("busy_at_done", BUSY, 0);
          chk("bus_idle_at_done", {SCL, SDA_OE}, 2'b10);
          chk("start_conditions", start_cnt, 1);
          chk("stop_conditions", stop_cnt, 1);
          chk("scl_rises", bits.size(), 9 * nb + 1);
          for (int j = 0; j < nb; j++) begin
            logic [7:0] b;
            b = '0;
            if (bits.size() >= 9 * j + 8) begin
              for (int k = 0; k < 8; k++) b = {b[6:0], bits[9 * j + k]};
            end
            chk($sformatf("byte%0d", j), b, 32'(mon_e[23 - 8 * j -: 8]));
          end
        end
        in_txn = 1'b0;
      end

      if (BUSY) begin
        if (busy_low_len > 0) last_busy_low_len = busy_low_len;
        busy_low_len = 0;
      end else begin
        busy_low_len++;
      end

      // inputs as the coming edge will see them
      if (!BUSY && START) begin
        in_txn    = 1'b1;
        tick_cnt  = 0;
        start_cnt = 0;
        stop_cnt  = 0;
        rise_cnt  = 0;
        bits.delete();
        accept_cnt++;
        accept_pend = 1'b1;
      end else if (in_txn && TICK) begin
        tick_cnt++;
        last_tick_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v,
                          input logic [2:0] m, input bit push);
    int guard;
    guard = 0;
    @(posedge CLK);
    #1;
    while (BUSY && guard < 2000) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (BUSY) chk("wait_idle_timeout", 1, 0);
    DEV_ADDR  = d;
    REG_ADDR  = r;
    DATA      = v;
    nack_mask = m;
    START     = 1'b1;
    if (push) exp_q.push_back(model(d, r, v, m));
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (done_cnt < target && g < 3000) begin
      @(posedge CLK);
      g++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, base, acc, g;
    logic [2:0] m;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_scl", SCL, 1);
    chk("reset_sda_oe", SDA_OE, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_ack_err", ACK_ERR, 0);
    chk("reset_state", STATE_DBG, ST_IDLE);
    RST_n = 1'b1;

    // idle for 20 ticks
    n = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      @(negedge CLK);
      if (TICK) begin
        n++;
        chk("idle_outputs", {SCL, SDA_OE, BUSY, DONE}, 4'b1000);
      end
    end
    chk("idle_ticks_seen", n, 20);

    // nominal write
    base = done_cnt;
    do_write(7'h39, 8'h41, 8'h10, 3'b000, 1);
    wait_done(base + 1);

    // NACK on the register-address byte
    base = done_cnt;
    do_write(7'h39, 8'h41, 8'h10, 3'b010, 1);
    wait_done(base + 1);

    // START pulses while busy with changed DATA are ignored
    base = done_cnt;
    acc  = accept_cnt;
    do_write(7'h39, 8'h41, 8'h10, 3'b000, 1);
    for (int p = 0; p < 5; p++) begin
      repeat ($urandom_range(3, 12)) @(posedge CLK);
      #1;
      DATA  = 8'hFF;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
    end
    wait_done(base + 1);
    repeat (50) @(posedge CLK);
    #1;
    chk("no_extra_accept", accept_cnt, acc + 1);
    chk("idle_after_busy_pulses", BUSY, 0);

    // reset in the middle of a transfer
    base = done_cnt;
    do_write(7'h39, 8'h41, 8'h10, 3'b000, 0);
    g = 0;
    while (tick_cnt < 50 && g < 1000) begin
      @(posedge CLK);
      g++;
    end
    chk("reached_tick50", 32'(tick_cnt >= 50), 1);
    #1;
    RST_n = 1'b0;
    #1;
    chk("midreset_scl", SCL, 1);
    chk("midreset_sda_oe", SDA_OE, 0);
    chk("midreset_busy", BUSY, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST_n = 1'b1;
    repeat (400) @(posedge CLK);
    chk("no_done_after_reset", done_cnt, base);
    do_write(7'h39, 8'h41, 8'h10, 3'b000, 1);
    wait_done(base + 1);

    // back-to-back writes with START held high
    base = done_cnt;
    acc  = accept_cnt;
    @(posedge CLK);
    #1;
    DEV_ADDR  = 7'h2A;
    REG_ADDR  = 8'h5C;
    DATA      = 8'hA3;
    nack_mask = 3'b000;
    START     = 1'b1;
    exp_q.push_back(model(7'h2A, 8'h5C, 8'hA3, 3'b000));
    exp_q.push_back(model(7'h2A, 8'h5C, 8'hA3, 3'b000));
    g = 0;
    while (accept_cnt < acc + 2 && g < 3000) begin
      @(posedge CLK);
      #1;
      g++;
    end
    START = 1'b0;
    chk("second_accept", accept_cnt, acc + 2);
    repeat (2) @(negedge CLK);
    chk("busy_low_gap", last_busy_low_len, 1);
    wait_done(base + 2);

    // randomized writes
    for (int i = 0; i < 8; i++) begin
      m = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
      base = done_cnt;
      do_write(7'($urandom), 8'($urandom), 8'($urandom), m, 1);
      wait_done(base + 1);
    end

    repeat (10) @(posedge CLK);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_reg_writer.md
# i2c_reg_writer

Single-register I2C write initiator for the HDMI lab design: on a start request it issues START, three bytes (device address + W, register address, data) and STOP on SCL/SDA, and reports completion and acknowledge status. It is the consumer of the I2C clock-enable produced by the clock source. It runs entirely on the system clock, with bit timing paced by a one-cycle `TICK` strobe at 4× the SCL rate. The HDMI transmitter configuration sequencer drives it, one register per request.

## Interface
- `CLK_TICKS_PER_BIT`, 4: ticks per SCL bit period; fixed value, listed for documentation only.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST_n`  in  1  asynchronous, active-low reset.
- `TICK`  in  1  one-`CLK`-cycle strobe; the FSM advances only on cycles with `TICK=1`.
- `START`  in  1  write request; sampled only while `BUSY=0`.
- `DEV_ADDR`  in  7  7-bit device address; latched on accept.
- `REG_ADDR`  in  8  register address; latched on accept.
- `DATA`  in  8  register data; latched on accept.
- `BUSY`  out  1  high from the cycle after accept until `DONE`.
- `DONE`  out  1  one-`CLK` pulse at the end of a transaction.
- `ACK_ERR`  out  1  at least one NACK occurred in the last transaction; valid with `DONE`, held until the next accept.
- `SCL`  out  1  serial clock, push-pull; idle high.
- `SDA_OE`  out  1  1 = pull SDA low; 0 = release SDA.
- `SDA_I`  in  1  sampled SDA line.

## Operation
- States: IDLE, START, BYTE, ACK, STOP, FIN.
- IDLE: `SCL=1`, `SDA_OE=0`.
  - `START=1` → latch inputs, clear `ACK_ERR`, set byte index 0, go to START.
  - Accept takes effect on the `CLK` edge; it is not gated by `TICK`.
- Each state step consumes exactly one `TICK`. The phase counter is 2 bits.
- START (2 ticks):
  - t0: `SDA_OE=1` with `SCL=1`.
  - t1: `SCL=0`.
- BYTE (8 bits × 4 ticks, MSB first). Per bit:
  - p0: `SCL=0`, `SDA_OE=~bit`.
  - p1: `SCL=1`.
  - p2: `SCL=1`.
  - p3: `SCL=0`.
- Byte sequence: byte 0 = `{DEV_ADDR,1'b0}`, byte 1 = `REG_ADDR`, byte 2 = `DATA`.
- ACK (4 ticks, same SCL phasing):
  - `SDA_OE=0` for the whole bit.
  - `SDA_I` is sampled at p2; `SDA_I=1` sets `ACK_ERR`.
  - Then byte index +1. Index < 3 → BYTE; otherwise → STOP.
- STOP (3 ticks):
  - t0: `SCL=0`, `SDA_OE=1`.
  - t1: `SCL=1`.
  - t2: `SDA_OE=0`.
- FIN: on the next `CLK` cycle (no tick needed), `DONE=1` and `BUSY=0`, then go to IDLE.
- Transaction length: 2 + 108 + 3 = 113 ticks.
- `START` held high after `DONE` is accepted again in the following cycle (back-to-back writes).
- `START` while `BUSY=1` is ignored. Input changes while busy have no effect.
- `TICK` and accept in the same cycle: accept only; the first START step waits for the next `TICK`.
- `RST_n` low mid-transaction: all outputs go to reset values immediately.
  - The bus is released (`SCL=1`, `SDA_OE=0`). No STOP is generated.
  - No `DONE` pulse.

## Timing
- Reset values: `SCL=1`, `SDA_OE=0`, `BUSY=0`, `DONE=0`, `ACK_ERR=0`, FSM=IDLE.
- All outputs are registered. `SCL` and `SDA_OE` change on the `CLK` edge where `TICK=1`.
- `BUSY` rises 1 cycle after the `START` accept edge.
- `DONE` is asserted 1 cycle after the 113th tick. `BUSY` falls in that same cycle.
- SDA changes only while `SCL=0`, except during the START and STOP conditions.

## Configuration
- `I2C_WRITER_ABORT_ON_NACK_EN` defined:
  - A NACK at any ACK bit jumps directly to STOP on the next tick. Remaining bytes are skipped.
  - Example: NACK on byte 0 → 2 + 36 + 3 = 41 ticks.
- Undefined:
  - All three bytes are always sent.
  - `ACK_ERR` is sticky across the transaction.

## Structure
- Shared package `i2c_pkg`:
  - state encoding constants;
  - `I2C_NUM_BYTES=3`;
  - `I2C_START_TICKS=2`;
  - `I2C_STOP_TICKS=3`;
  - phase constants P0–P3.
- Sub-module `i2c_bit_phase`: 2-bit phase counter plus bit counter, advanced by `TICK`. Outputs `last_phase` and `last_bit` to the FSM.
- Shift register, byte mux and FSM live in the top.

## Test plan
- Reset, then idle for 20 ticks → `SCL=1`, `SDA_OE=0`, `BUSY=0`, `DONE=0` throughout.
- `DEV_ADDR=0x39`, `REG_ADDR=0x41`, `DATA=0x10`, `SDA_I=0` at every ACK:
  - Decoded SCL-rising bytes are 0x72, 0x41, 0x10.
  - `DONE` occurs exactly 1 cycle after tick 113.
  - `ACK_ERR=0`.
- `SDA_I=1` at the byte-1 ACK:
  - Without the macro: 113 ticks, `ACK_ERR=1`, byte 0x10 still sent.
  - With the macro: STOP follows immediately, 2 + 72 + 3 = 77 ticks, `ACK_ERR=1`.
- `START` pulsed 5 times while `BUSY`, with changed `DATA=0xFF` → only 0x10 is transmitted. No second transaction.
- `RST_n` asserted at tick 50:
  - Same cycle: `SCL=1`, `SDA_OE=0`, `BUSY=0`.
  - No `DONE`.
  - A new request after release completes normally.
- `START` held high continuously → a second transaction is accepted the cycle after the first `DONE`. `BUSY` is low for exactly 1 cycle between them.
